// File: rtl/aoc_pkg.sv
// rtl/aoc_pkg.sv - shared types and constants for the merge pass engine
package aoc_pkg;

    localparam int LANES      = 2;
    localparam int DEF_ELEM_W = 64;

    // One memory row: even lane (element 2r) and odd lane (element 2r+1).
    typedef struct packed {
        logic [DEF_ELEM_W-1:0] even;
        logic [DEF_ELEM_W-1:0] odd;
    } tuple_pair_t;

    // Filler written into the odd lane of a half-populated final row.
    localparam logic [DEF_ELEM_W-1:0] PAD_ELEM = '1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHECK     = 3'd1,
        ST_PASS_INIT = 3'd2,
        ST_MERGE     = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_FINISH    = 3'd5
    } merge_state_e;

    // Which lanes of a fetched row become holder entries.
    localparam logic [1:0] LOAD_BOTH = 2'd0;
    localparam logic [1:0] LOAD_EVEN = 2'd1;
    localparam logic [1:0] LOAD_ODD  = 2'd2;

endpackage

// File: rtl/merge_side_buf.sv
// rtl/merge_side_buf.sv - per-run fetch pointer and two-entry element holder
module merge_side_buf
    import aoc_pkg::*;
#(
    parameter int ELEM_W = 64,
    parameter int ADDR_W = 10,
    parameter int IDX_W  = ADDR_W + 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              init,
    input  logic [IDX_W-1:0]  init_start,
    input  logic [IDX_W-1:0]  init_end,
    input  logic              issue,
    input  logic              pop,
    input  logic [ELEM_W-1:0] rd_even,
    input  logic [ELEM_W-1:0] rd_odd,
    output logic              req,
    output logic [ADDR_W-1:0] row,
    output logic [ELEM_W-1:0] head,
    output logic              head_valid,
    output logic              exhausted
);

    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  end_idx;
    logic              pend;
    logic [1:0]        mode;
    logic [1:0]        count;
    logic [ELEM_W-1:0] front;
    logic [ELEM_W-1:0] back;
    logic              fetch_done;

    // Read data returns one cycle after issue, so pend marks "the bus is ours this cycle".
    assign fetch_done = (ptr >= end_idx);
    assign req        = (count == 2'd0) && !pend && !fetch_done;
    assign row        = ptr[ADDR_W:1];
    assign head       = front;
    assign head_valid = (count != 2'd0);
    assign exhausted  = fetch_done && (count == 2'd0) && !pend;

    // Fetch pointer advance, lane selection at issue, holder load and pop.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr     <= '0;
            end_idx <= '0;
            pend    <= 1'b0;
            mode    <= LOAD_BOTH;
            count   <= 2'd0;
            front   <= '0;
            back    <= '0;
        end else if (init) begin
            ptr     <= init_start;
            end_idx <= init_end;
            pend    <= 1'b0;
            count   <= 2'd0;
        end else begin
            pend <= issue;
            if (issue) begin
                // An odd head skips the even lane; a lane at or past the run end is never taken.
                if (ptr[0]) begin
                    mode <= LOAD_ODD;
                    ptr  <= ptr + IDX_W'(1);
                end else if ((ptr + IDX_W'(1)) < end_idx) begin
                    mode <= LOAD_BOTH;
                    ptr  <= ptr + IDX_W'(2);
                end else begin
                    mode <= LOAD_EVEN;
                    ptr  <= ptr + IDX_W'(1);
                end
            end
            if (pend) begin
                case (mode)
                    LOAD_BOTH: begin
                        front <= rd_even;
                        back  <= rd_odd;
                        count <= 2'd2;
                    end
                    LOAD_EVEN: begin
                        front <= rd_even;
                        count <= 2'd1;
                    end
                    default: begin
                        front <= rd_odd;
                        count <= 2'd1;
                    end
                endcase
            end else if (pop) begin
                front <= back;
                count <= count - 2'd1;
            end
        end
    end

endmodule

// File: rtl/merge_pass_engine.sv
// rtl/merge_pass_engine.sv - bottom-up ping-pong merge sort over 2-lane row memories
module merge_pass_engine
    import aoc_pkg::*;
#(
    parameter int ELEM_W    = 64,
    parameter int ADDR_W    = 10,
    parameter int START_RUN = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start_in,
    input  logic [ADDR_W+1:0] len_in,
    input  logic              descend_in,
    output logic              busy_out,
    output logic              done_out,
    output logic              err_out,
    output logic              result_bank,
    output logic              rd_en_out,
    output logic              rd_bank_out,
    output logic [ADDR_W-1:0] rd_addr_out,
    input  logic [ELEM_W-1:0] rd_even_in,
    input  logic [ELEM_W-1:0] rd_odd_in,
    output logic              wr_en_out,
    output logic              wr_bank_out,
    output logic [ADDR_W-1:0] wr_addr_out,
    output logic [ELEM_W-1:0] wr_even_out,
    output logic [ELEM_W-1:0] wr_odd_out
);

    localparam int IDX_W  = ADDR_W + 2;
    localparam int WIDE_W = ADDR_W + 4;
    localparam logic [IDX_W-1:0] CAPACITY = {1'b1, {(ADDR_W+1){1'b0}}};

    merge_state_e      state;
    logic [IDX_W-1:0]  len_q;
    logic [IDX_W-1:0]  w_q;
    logic [IDX_W-1:0]  base_q;
    logic              desc_q;
    logic              src_bank;
    logic              stage_half;
    logic [ELEM_W-1:0] stage_even;
    logic [ADDR_W-1:0] wr_addr_q;

    logic              req_a, req_b, valid_a, valid_b, exh_a, exh_b;
    logic [ADDR_W-1:0] row_a, row_b;
    logic [ELEM_W-1:0] head_a, head_b, emit_elem;
    logic              in_merge, issue_a, issue_b, take_a, emit, pop_a, pop_b;
    logic              pair_done, more_pairs, init_sides;
    logic [WIDE_W-1:0] len_w, w_w, base_next, base_sel, a_end_w, b_end_w;
    logic [IDX_W-1:0]  w_shift;

    assign busy_out    = (state != ST_IDLE);
    assign done_out    = (state == ST_FINISH);
    assign rd_bank_out = src_bank;
    assign wr_bank_out = ~src_bank;
    assign wr_addr_out = wr_addr_q;

    // Read arbitration, merge compare and run-pair pointer generation.
    always_comb begin
        in_merge  = (state == ST_MERGE);
        issue_a   = in_merge && req_a;
        issue_b   = in_merge && req_b && !req_a;
        rd_en_out = issue_a || issue_b;
        rd_addr_out = issue_a ? row_a : (issue_b ? row_b : '0);

        // Exhausted sides act as an infinite sentinel purely through flags; equal keys favour A.
        take_a = valid_a && (!valid_b ||
                 (desc_q ? (head_a >= head_b) : (head_a <= head_b)));
        emit   = in_merge && ((valid_a && (valid_b || exh_b)) || (valid_b && exh_a));
        pop_a  = emit && take_a;
        pop_b  = emit && !take_a;
        emit_elem = take_a ? head_a : head_b;

        len_w      = WIDE_W'(len_q);
        w_w        = WIDE_W'(w_q);
        base_next  = WIDE_W'(base_q) + (w_w << 1);
        pair_done  = in_merge && exh_a && exh_b;
        more_pairs = (base_next < len_w);
        init_sides = (state == ST_PASS_INIT) || (pair_done && more_pairs);
        base_sel   = (state == ST_PASS_INIT) ? '0 : base_next;
        a_end_w    = ((base_sel + w_w) < len_w) ? (base_sel + w_w) : len_w;
        b_end_w    = ((base_sel + (w_w << 1)) < len_w) ? (base_sel + (w_w << 1)) : len_w;

        w_shift = w_q[IDX_W-1] ? '1 : {w_q[IDX_W-2:0], 1'b0};
    end

    merge_side_buf #(.ELEM_W(ELEM_W), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) u_side_a (
        .clock      (clock),
        .reset_n    (reset_n),
        .init       (init_sides),
        .init_start (IDX_W'(base_sel)),
        .init_end   (IDX_W'(a_end_w)),
        .issue      (issue_a),
        .pop        (pop_a),
        .rd_even    (rd_even_in),
        .rd_odd     (rd_odd_in),
        .req        (req_a),
        .row        (row_a),
        .head       (head_a),
        .head_valid (valid_a),
        .exhausted  (exh_a)
    );

    merge_side_buf #(.ELEM_W(ELEM_W), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) u_side_b (
        .clock      (clock),
        .reset_n    (reset_n),
        .init       (init_sides),
        .init_start (IDX_W'(a_end_w)),
        .init_end   (IDX_W'(b_end_w)),
        .issue      (issue_b),
        .pop        (pop_b),
        .rd_even    (rd_even_in),
        .rd_odd     (rd_odd_in),
        .req        (req_b),
        .row        (row_b),
        .head       (head_b),
        .head_valid (valid_b),
        .exhausted  (exh_b)
    );

    // Sort sequencing: length check, pass loop, bank ping-pong and completion.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            len_q       <= '0;
            desc_q      <= 1'b0;
            w_q         <= '0;
            base_q      <= '0;
            src_bank    <= 1'b0;
            result_bank <= 1'b0;
            err_out     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_in) begin
                        len_q       <= len_in;
                        desc_q      <= descend_in;
                        err_out     <= 1'b0;
                        src_bank    <= 1'b0;
                        result_bank <= 1'b0;
                        state       <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (len_q > CAPACITY) begin
                        err_out <= 1'b1;
                        state   <= ST_FINISH;
                    end else if (len_q <= IDX_W'(START_RUN)) begin
                        state <= ST_FINISH;
                    end else begin
                        w_q   <= IDX_W'(START_RUN);
                        state <= ST_PASS_INIT;
                    end
                end
                ST_PASS_INIT: begin
                    base_q <= '0;
                    state  <= ST_MERGE;
                end
                ST_MERGE: begin
                    if (pair_done) begin
                        if (more_pairs) begin
                            base_q <= IDX_W'(base_next);
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Hold the bank until the last (possibly padded) row write has left.
                    if (!stage_half && !wr_en_out) begin
                        src_bank <= ~src_bank;
                        w_q      <= w_shift;
                        if (w_shift >= len_q) begin
                            result_bank <= ~src_bank;
                            state       <= ST_FINISH;
                        end else begin
                            state <= ST_PASS_INIT;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Pair emitted elements into rows and issue registered writes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stage_half  <= 1'b0;
            stage_even  <= '0;
            wr_en_out   <= 1'b0;
            wr_even_out <= '0;
            wr_odd_out  <= '0;
            wr_addr_q   <= '0;
        end else begin
            wr_en_out <= 1'b0;
            if (wr_en_out) begin
                wr_addr_q <= wr_addr_q + ADDR_W'(1);
            end
            if (state == ST_PASS_INIT) begin
                stage_half <= 1'b0;
                wr_addr_q  <= '0;
            end else if (emit) begin
                if (!stage_half) begin
                    stage_even <= emit_elem;
                    stage_half <= 1'b1;
                end else begin
                    wr_even_out <= stage_even;
                    wr_odd_out  <= emit_elem;
                    wr_en_out   <= 1'b1;
                    stage_half  <= 1'b0;
                end
            end else if ((state == ST_DRAIN) && stage_half) begin
                wr_even_out <= stage_even;
                wr_odd_out  <= {ELEM_W{1'b1}};
                wr_en_out   <= 1'b1;
                stage_half  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_merge_pass_engine.sv
// tb/tb_merge_pass_engine.sv - directed self-checking bench for merge_pass_engine
module tb_merge_pass_engine;

    localparam int ELEM_W    = 64;
    localparam int ADDR_W    = 11;
    localparam int START_RUN = 16;
    localparam int IDX_W     = ADDR_W + 2;
    localparam int ROWS      = 2 ** ADDR_W;
    localparam logic [ELEM_W-1:0] ONES = '1;
    localparam logic [ELEM_W-1:0] FILL = 64'hA5A5_5A5A_C3C3_3C3C;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              start_in = 1'b0;
    logic [IDX_W-1:0]  len_in = '0;
    logic              descend_in = 1'b0;
    logic              busy_out, done_out, err_out, result_bank;
    logic              rd_en_out, rd_bank_out, wr_en_out, wr_bank_out;
    logic [ADDR_W-1:0] rd_addr_out, wr_addr_out;
    logic [ELEM_W-1:0] rd_even_in = '0, rd_odd_in = '0, wr_even_out, wr_odd_out;

    merge_pass_engine #(.ELEM_W(ELEM_W), .ADDR_W(ADDR_W), .START_RUN(START_RUN)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start_in    (start_in),
        .len_in      (len_in),
        .descend_in  (descend_in),
        .busy_out    (busy_out),
        .done_out    (done_out),
        .err_out     (err_out),
        .result_bank (result_bank),
        .rd_en_out   (rd_en_out),
        .rd_bank_out (rd_bank_out),
        .rd_addr_out (rd_addr_out),
        .rd_even_in  (rd_even_in),
        .rd_odd_in   (rd_odd_in),
        .wr_en_out   (wr_en_out),
        .wr_bank_out (wr_bank_out),
        .wr_addr_out (wr_addr_out),
        .wr_even_out (wr_even_out),
        .wr_odd_out  (wr_odd_out)
    );

    always #5 clock = ~clock;

    logic [ELEM_W-1:0] mem_even [0:1][0:ROWS-1];
    logic [ELEM_W-1:0] mem_odd  [0:1][0:ROWS-1];
    logic [ELEM_W-1:0] vals     [0:127];
    logic [ELEM_W-1:0] exp_vals [0:127];
    logic [ELEM_W-1:0] pad_garbage = '0;
    logic              load_req = 1'b0;
    int                load_len = 0;
    int                passed = 0;
    int                total = 0;
    int                rd_count = 0, wr_count = 0, max_rd_row = 0, bank_err = 0;

    // Row memory model with 1-cycle read latency, plus bench preload port.
    always @(posedge clock) begin
        if (load_req) begin
            for (int r = 0; r < 64; r++) begin
                mem_even[0][r] = (2*r < load_len) ? vals[2*r] : pad_garbage;
                mem_odd[0][r]  = (2*r+1 < load_len) ? vals[2*r+1] : pad_garbage;
                mem_even[1][r] = FILL;
                mem_odd[1][r]  = FILL;
            end
        end else begin
            if (rd_en_out) begin
                rd_even_in <= mem_even[rd_bank_out][rd_addr_out];
                rd_odd_in  <= mem_odd[rd_bank_out][rd_addr_out];
            end
            if (wr_en_out) begin
                mem_even[wr_bank_out][wr_addr_out] = wr_even_out;
                mem_odd[wr_bank_out][wr_addr_out]  = wr_odd_out;
            end
        end
    end

    // Traffic counters, cleared on each accepted start.
    always @(posedge clock) begin
        if (wr_bank_out !== ~rd_bank_out) bank_err++;
        if (start_in && !busy_out) begin
            rd_count = 0;
            wr_count = 0;
            max_rd_row = 0;
        end else begin
            if (rd_en_out) begin
                rd_count++;
                if (int'(rd_addr_out) > max_rd_row) max_rd_row = int'(rd_addr_out);
            end
            if (wr_en_out) wr_count++;
        end
    end

    function automatic logic [ELEM_W-1:0] mem_elem(input logic bank, input int idx);
        return idx[0] ? mem_odd[bank][idx >> 1] : mem_even[bank][idx >> 1];
    endfunction

    task automatic sort_exp(input int lo, input int hi, input bit desc);
        for (int i = lo + 1; i < hi; i++) begin
            logic [ELEM_W-1:0] k;
            int j;
            k = exp_vals[i];
            j = i - 1;
            while (j >= lo && (desc ? (exp_vals[j] < k) : (exp_vals[j] > k))) begin
                exp_vals[j+1] = exp_vals[j];
                j--;
            end
            exp_vals[j+1] = k;
        end
    endtask

    // exp_vals holds raw data on entry: presort each run into vals, then fully sort exp_vals.
    task automatic prep_runs(input int n, input bit desc);
        for (int lo = 0; lo < n; lo += START_RUN)
            sort_exp(lo, (lo + START_RUN < n) ? lo + START_RUN : n, desc);
        for (int i = 0; i < n; i++) vals[i] = exp_vals[i];
        sort_exp(0, n, desc);
    endtask

    task automatic load_mem(input int n, input logic [ELEM_W-1:0] garbage);
        @(posedge clock); #1;
        pad_garbage = garbage;
        load_len = n;
        load_req = 1'b1;
        @(posedge clock); #1;
        load_req = 1'b0;
    endtask

    task automatic run_sort(input int n, input bit desc, output bit done_seen, output int edges);
        @(posedge clock); #1;
        start_in = 1'b1;
        len_in = IDX_W'(n);
        descend_in = desc;
        @(posedge clock); #1;
        start_in = 1'b0;
        done_seen = 1'b0;
        edges = -1;
        for (int c = 0; c < 20000; c++) begin
            if (done_out) begin
                done_seen = 1'b1;
                edges = c;
                break;
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset();
        #1;
        total++; if (busy_out !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_out); else passed++;
        total++; if (done_out !== 1'b0) $display("FAIL reset_done: got %b expected 0", done_out); else passed++;
        total++; if ({err_out, result_bank, rd_en_out, wr_en_out} !== 4'b0)
            $display("FAIL reset_flags: got %b expected 0000", {err_out, result_bank, rd_en_out, wr_en_out}); else passed++;
        total++; if ({rd_addr_out, wr_addr_out, rd_bank_out} !== '0)
            $display("FAIL reset_addr: got rd=%0d wr=%0d bank=%b expected 0", rd_addr_out, wr_addr_out, rd_bank_out); else passed++;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_one_pass();
        bit ok; int e;
        for (int i = 0; i < 32; i++) vals[i] = (i < 16) ? ELEM_W'(2*i) : ELEM_W'(2*(i-16)+1);
        load_mem(32, '0);
        run_sort(32, 1'b0, ok, e);
        total++; if (!ok) $display("FAIL t1_done: got timeout expected done_out"); else passed++;
        total++; if (result_bank !== 1'b1) $display("FAIL t1_result_bank: got %b expected 1", result_bank); else passed++;
        total++; if (wr_count !== 16) $display("FAIL t1_writes: got %0d expected 16", wr_count); else passed++;
        for (int i = 0; i < 32; i++) begin
            total++;
            if (mem_elem(1'b1, i) !== ELEM_W'(i)) $display("FAIL t1_elem[%0d]: got %0h expected %0h", i, mem_elem(1'b1, i), i);
            else passed++;
        end
        @(posedge clock); #1;
        total++; if ({done_out, busy_out} !== 2'b00) $display("FAIL t1_done_pulse: got done,busy=%b expected 00", {done_out, busy_out}); else passed++;
    endtask

    task automatic test_desc_two_pass();
        bit ok; int e;
        for (int i = 0; i < 64; i++) exp_vals[i] = {$urandom(), $urandom()};
        exp_vals[5] = exp_vals[40];
        prep_runs(64, 1'b1);
        load_mem(64, ONES);
        run_sort(64, 1'b1, ok, e);
        total++; if (!ok) $display("FAIL t2_done: got timeout expected done_out"); else passed++;
        total++; if (result_bank !== 1'b0) $display("FAIL t2_result_bank: got %b expected 0", result_bank); else passed++;
        total++; if (wr_count !== 64) $display("FAIL t2_writes: got %0d expected 64", wr_count); else passed++;
        for (int i = 0; i < 64; i++) begin
            total++;
            if (mem_elem(1'b0, i) !== exp_vals[i]) $display("FAIL t2_elem[%0d]: got %0h expected %0h", i, mem_elem(1'b0, i), exp_vals[i]);
            else passed++;
        end
    endtask

    task automatic test_odd_tail();
        bit ok; int e;
        for (int i = 0; i < 37; i++) exp_vals[i] = ELEM_W'((i * 29 + 7) % 23 + 1);
        prep_runs(37, 1'b0);
        load_mem(37, '0);
        run_sort(37, 1'b0, ok, e);
        total++; if (!ok) $display("FAIL t3_done: got timeout expected done_out"); else passed++;
        total++; if (result_bank !== 1'b0) $display("FAIL t3_result_bank: got %b expected 0", result_bank); else passed++;
        total++; if (max_rd_row > 18) $display("FAIL t3_max_read_row: got %0d expected <=18", max_rd_row); else passed++;
        total++; if (wr_count !== 38) $display("FAIL t3_writes: got %0d expected 38", wr_count); else passed++;
        total++; if (mem_odd[0][18] !== ONES) $display("FAIL t3_pad_lane: got %0h expected %0h", mem_odd[0][18], ONES); else passed++;
        for (int i = 0; i < 37; i++) begin
            total++;
            if (mem_elem(1'b0, i) !== exp_vals[i]) $display("FAIL t3_elem[%0d]: got %0h expected %0h", i, mem_elem(1'b0, i), exp_vals[i]);
            else passed++;
        end
    endtask

    task automatic test_equal_keys();
        bit ok; int e;
        for (int i = 0; i < 40; i++) exp_vals[i] = (i % 3 == 0) ? '0 : ONES;
        prep_runs(40, 1'b0);
        load_mem(40, '0);
        run_sort(40, 1'b0, ok, e);
        total++; if (!ok) $display("FAIL t4_done: got timeout expected done_out"); else passed++;
        total++; if (wr_count !== 40) $display("FAIL t4_writes: got %0d expected 40", wr_count); else passed++;
        for (int i = 0; i < 40; i++) begin
            total++;
            if (mem_elem(1'b0, i) !== ((i < 14) ? '0 : ONES))
                $display("FAIL t4_elem[%0d]: got %0h expected %0h", i, mem_elem(1'b0, i), (i < 14) ? '0 : ONES);
            else passed++;
        end
    endtask

    task automatic test_short_and_error();
        bit ok; int e;
        run_sort(8, 1'b0, ok, e);
        total++; if (!ok) $display("FAIL t5_short_done: got timeout expected done_out"); else passed++;
        total++; if (rd_count + wr_count !== 0) $display("FAIL t5_short_traffic: got %0d expected 0", rd_count + wr_count); else passed++;
        total++; if ({result_bank, err_out} !== 2'b00) $display("FAIL t5_short_flags: got %b expected 00", {result_bank, err_out}); else passed++;
        run_sort(0, 1'b0, ok, e);
        total++; if (e !== 1) $display("FAIL t5_zero_latency: got %0d expected 1", e); else passed++;
        run_sort(5000, 1'b0, ok, e);
        total++; if (!ok) $display("FAIL t5_err_done: got timeout expected done_out"); else passed++;
        total++; if (err_out !== 1'b1) $display("FAIL t5_err: got %b expected 1", err_out); else passed++;
        total++; if (rd_count + wr_count !== 0) $display("FAIL t5_err_traffic: got %0d expected 0", rd_count + wr_count); else passed++;
        repeat (3) @(posedge clock);
        #1;
        total++; if (err_out !== 1'b1) $display("FAIL t5_err_sticky: got %b expected 1", err_out); else passed++;
        run_sort(4, 1'b0, ok, e);
        total++; if (err_out !== 1'b0) $display("FAIL t5_err_cleared: got %b expected 0", err_out); else passed++;
    endtask

    task automatic test_reset_and_busy_start();
        bit ok;
        for (int i = 0; i < 64; i++) exp_vals[i] = {$urandom(), $urandom()};
        prep_runs(64, 1'b1);
        load_mem(64, ONES);
        @(posedge clock); #1;
        start_in = 1'b1; len_in = IDX_W'(64); descend_in = 1'b1;
        @(posedge clock); #1;
        start_in = 1'b0;
        repeat (30) @(posedge clock);
        #1;
        total++; if (busy_out !== 1'b1) $display("FAIL t6_busy_mid: got %b expected 1", busy_out); else passed++;
        reset_n = 1'b0;
        #1;
        total++; if ({busy_out, done_out, rd_en_out, wr_en_out, result_bank} !== 5'b0)
            $display("FAIL t6_async_reset: got %b expected 00000", {busy_out, done_out, rd_en_out, wr_en_out, result_bank}); else passed++;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 32; i++) vals[i] = (i < 16) ? ELEM_W'(2*i) : ELEM_W'(2*(i-16)+1);
        load_mem(32, '0);
        @(posedge clock); #1;
        start_in = 1'b1; len_in = IDX_W'(32); descend_in = 1'b0;
        @(posedge clock); #1;
        start_in = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        start_in = 1'b1; len_in = IDX_W'(8); descend_in = 1'b1;
        @(posedge clock); #1;
        start_in = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            if (done_out) begin ok = 1'b1; break; end
            @(posedge clock); #1;
        end
        total++; if (!ok) $display("FAIL t6_done: got timeout expected done_out"); else passed++;
        total++; if (result_bank !== 1'b1) $display("FAIL t6_result_bank: got %b expected 1", result_bank); else passed++;
        total++; if (wr_count !== 16) $display("FAIL t6_writes: got %0d expected 16", wr_count); else passed++;
        for (int i = 0; i < 32; i++) begin
            total++;
            if (mem_elem(1'b1, i) !== ELEM_W'(i)) $display("FAIL t6_elem[%0d]: got %0h expected %0h", i, mem_elem(1'b1, i), i);
            else passed++;
        end
        total++; if (bank_err !== 0) $display("FAIL bank_relation: got %0d violations expected 0", bank_err); else passed++;
    endtask

    initial begin
        test_reset();
        test_one_pass();
        test_desc_two_pass();
        test_odd_tail();
        test_equal_keys();
        test_short_and_error();
        test_reset_and_busy_start();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
